riscv_mul_iter: RTL and testbench
=================================

Name: riscv_mul_iter

Overview:
Parametrised iterative successor to the single-multiplier RV M-extension unit. Computes MUL/MULH/MULHSU/MULHU (and MULW when XLEN=64) with a radix-2^BITS_PER_CYCLE shift-add datapath instead of one full-width array. Uses valid/ready handshakes on request and response, and supports flush. A one-entry product cache returns a MUL that follows an MULH-family op with identical operands in a single cycle. It sits in the EX stage beside the ALU and drives the writeback mux.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
BITS_PER_CYCLE, 4, multiplier bits consumed per iteration; power of 2 in 1..16 that divides 32.
ENABLE_CACHE, 1, 1 enables the product cache; 0 means no cache hit ever occurs.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush; aborts the current operation
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request; high only in IDLE and not in reset
req_op  in  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
req_word  in  1  MULW; honoured only when XLEN=64, ignored when XLEN=32
req_opa  in  XLEN  operand A (rs1)
req_opb  in  XLEN  operand B (rs2)
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts the result
rsp_result  out  XLEN  result
busy  out  1  state is not IDLE

Behaviour:
- Reset (rst=1 at a rising edge) forces the following: state=IDLE, rsp_valid=0, rsp_result=0, busy=0, cache invalid. req_ready=0 while rst=1.
- Accept: a request is accepted when req_valid & req_ready are high at a rising edge. The operands, op and word flag are registered on that edge.
- Operand prep:
  - Word op: operands are sign-extended from bit 31.
  - Operand A magnitude: taken as-is for MULHU, otherwise abs.
  - Operand B magnitude: taken as-is for MULHSU and MULHU, otherwise abs.
  - neg flag: MUL/MULH use signA^signB; MULHSU uses signA; MULHU uses 0; word op uses opa[31]^opb[31].
- States:
  - IDLE: on accept, go to DONE if there is a cache hit, else go to CALC with cnt=N-1 and acc=0.
  - CALC: each cycle, acc += magA * magB[BPC-1:0] << (iter*BPC), then magB >>= BPC. When cnt==0, go to SIGN; otherwise decrement cnt.
  - SIGN: acc = neg ? two's-complement of acc (2*XLEN bits) : acc. Select the result and go to DONE:
    - MUL: low XLEN bits.
    - word op: sign-extend of acc[31:0].
    - otherwise: high XLEN bits.
  - DONE: rsp_valid=1 and rsp_result is held stable. When rsp_ready=1, go to IDLE and drop rsp_valid on that edge.
- Iteration count: N = XLEN/BITS_PER_CYCLE, or 32/BITS_PER_CYCLE for a word op. The accumulator is 2*XLEN bits and never overflows because magnitudes are unsigned.
- Latency, with the accept cycle as c0:
  - Computed op: rsp_valid first high in cycle c0+N+2.
  - Cache hit: rsp_valid first high in c0+1.
  - Back-to-back: the earliest next accept is the cycle after the rsp handshake. Throughput is therefore at most one op per N+3 cycles.
- Cache:
  - Filled in SIGN by any non-word computed op: stores opa, opb, op, and the signed 2*XLEN product.
  - Hit condition: ENABLE_CACHE=1, cache valid, req_word=0, opa and opb equal the stored values, and (req_op==MUL or req_op==stored op).
  - Hit result: the low or high half of the stored product, chosen by req_op.
  - Word ops never hit and never fill the cache.
- Flush: if flush=1 at an edge, in any state, the next state is IDLE, rsp_valid=0 and the cache is invalidated. Flush has priority over accept and over the rsp handshake in the same cycle, so the response is discarded and no request is accepted. rst has priority over flush.
- Stall of the consumer: with rsp_ready=0, DONE holds indefinitely and rsp_result does not change.
- Reset mid-operation: identical to the reset values above; no partial result is ever presented.

Test Plan:
- XLEN=32, BPC=4, MUL opa=0xFFFFFFFD (-3), opb=7, rsp_ready=1 -> rsp_result=0xFFFFFFEB, rsp_valid first high 10 cycles after accept, high for exactly 1 cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- Cache: MULHU 0xFFFFFFFF*0xFFFFFFFF, then MUL with the same operands -> 0x00000001 with rsp_valid in c0+1. A following MULH with the same operands misses and takes full latency -> 0x00000000.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_result stable and req_ready=0. Then rsp_ready=1 -> IDLE the next cycle.
- Flush: assert flush in the 3rd CALC cycle -> rsp_valid never asserts, req_ready=1 the next cycle, and a following identical MUL misses the cache (full latency). Repeat with rst=1 mid-CALC -> same outcome.
- XLEN=64, BPC=8: MULW opa=0x7FFFFFFF, opb=2 -> 0xFFFFFFFFFFFFFFFE with latency 4+2=6. With BPC=1, a 64-bit MUL has latency 66.

Source files
------------

// File: rtl/riscv_mul_iter.sv
// riscv_mul_iter: iterative RV M-extension multiplier (MUL/MULH/MULHSU/MULHU,
// plus MULW when XLEN=64) built on a radix-2^BITS_PER_CYCLE shift-add
// datapath. A one-entry product cache answers a MUL that follows a
// MULH-family op on identical operands in a single cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   flush      in   aborts the current operation and invalidates the cache
//   req_valid  in   request valid
//   req_ready  out  request can be accepted (IDLE and not in reset)
//   req_op     in   0=MUL 1=MULH 2=MULHSU 3=MULHU
//   req_word   in   MULW (only honoured when XLEN=64)
//   req_opa    in   operand A (rs1)
//   req_opb    in   operand B (rs2)
//   rsp_valid  out  result valid, held until rsp_ready
//   rsp_ready  in   consumer accepts the result
//   rsp_result out  result
//   busy       out  unit is not idle
module riscv_mul_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int ENABLE_CACHE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_opa,
  input  logic [XLEN-1:0] req_opb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy
);

  localparam int PW     = 2 * XLEN;
  localparam int BPC    = BITS_PER_CYCLE;
  localparam int N_FULL = XLEN / BPC;
  localparam int N_WORD = 32 / BPC;
  localparam int CW     = $clog2(XLEN);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sign-extend a 32-bit value to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Registered state
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mag_a_q, mag_a_d;   // shifted left BPC each iteration
  logic [XLEN-1:0]   mag_b_q, mag_b_d;   // shifted right BPC each iteration
  logic              neg_q, neg_d;
  logic [1:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
  logic              busy_q, busy_d;
  logic              c_valid_q, c_valid_d;
  logic [XLEN-1:0]   c_opa_q, c_opa_d;
  logic [XLEN-1:0]   c_opb_q, c_opb_d;
  logic [1:0]        c_op_q, c_op_d;
  logic [PW-1:0]     c_prod_q, c_prod_d;

  // Combinational helpers
  logic              word_s;
  logic [XLEN-1:0]   opa_x_s, opb_x_s;
  logic              sign_a_s, sign_b_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              neg_s;
  logic              hit_s;
  logic [XLEN-1:0]   hit_result_s;
  logic [PW-1:0]     pp_s;
  logic [PW-1:0]     signed_prod_s;
  logic [XLEN-1:0]   sign_result_s;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

  // Operand preparation: word extension, magnitudes and result sign.
  always_comb begin
    if (XLEN == 64) begin
      word_s = req_word;
    end else begin
      word_s = 1'b0;
    end
    if (word_s) begin
      opa_x_s = sext32(req_opa[31:0]);
      opb_x_s = sext32(req_opb[31:0]);
    end else begin
      opa_x_s = req_opa;
      opb_x_s = req_opb;
    end
    sign_a_s = opa_x_s[XLEN-1];
    sign_b_s = opb_x_s[XLEN-1];
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    abs_a_s = sign_a_s ? (~opa_x_s + {{(XLEN-1){1'b0}}, 1'b1}) : opa_x_s;
    abs_b_s = sign_b_s ? (~opb_x_s + {{(XLEN-1){1'b0}}, 1'b1}) : opb_x_s;
    if (word_s) begin
      mag_a_s = abs_a_s;
      mag_b_s = abs_b_s;
      neg_s   = sign_a_s ^ sign_b_s;
    end else begin
      case (req_op)
        OP_MUL, OP_MULH: begin
          mag_a_s = abs_a_s;
          mag_b_s = abs_b_s;
          neg_s   = sign_a_s ^ sign_b_s;
        end
        OP_MULHSU: begin
          mag_a_s = abs_a_s;
          mag_b_s = opb_x_s;
          neg_s   = sign_a_s;
        end
        OP_MULHU: begin
          mag_a_s = opa_x_s;
          mag_b_s = opb_x_s;
          neg_s   = 1'b0;
        end
        default: begin
          mag_a_s = abs_a_s;
          mag_b_s = abs_b_s;
          neg_s   = sign_a_s ^ sign_b_s;
        end
      endcase
    end
  end

  // Product cache lookup against the incoming request.
  always_comb begin
    hit_s = (ENABLE_CACHE != 0) && c_valid_q && !word_s &&
            (req_opa == c_opa_q) && (req_opb == c_opb_q) &&
            ((req_op == OP_MUL) || (req_op == c_op_q));
    if (req_op == OP_MUL) begin
      hit_result_s = c_prod_q[XLEN-1:0];
    end else begin
      hit_result_s = c_prod_q[PW-1:XLEN];
    end
  end

  // Partial product of the shifted A magnitude with the low BPC bits of B.
  always_comb begin
    pp_s = {PW{1'b0}};
    for (int i = 0; i < BPC; i++) begin
      if (mag_b_q[i]) begin
        pp_s = pp_s + (mag_a_q << i);
      end else begin
        pp_s = pp_s;
      end
    end
  end

  // Sign fix-up of the accumulated magnitude and result selection.
  always_comb begin
    if (neg_q) begin
      signed_prod_s = ~acc_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      signed_prod_s = acc_q;
    end
    if (word_q) begin
      sign_result_s = sext32(signed_prod_s[31:0]);
    end else if (op_q == OP_MUL) begin
      sign_result_s = signed_prod_s[XLEN-1:0];
    end else begin
      sign_result_s = signed_prod_s[PW-1:XLEN];
    end
  end

  // Next-state logic for the FSM, datapath and cache.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mag_a_d      = mag_a_q;
    mag_b_d      = mag_b_q;
    neg_d        = neg_q;
    op_d         = op_q;
    word_d       = word_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    c_valid_d    = c_valid_q;
    c_opa_d      = c_opa_q;
    c_opb_d      = c_opb_q;
    c_op_d       = c_op_q;
    c_prod_d     = c_prod_q;
    if (flush) begin
      // Flush beats both accept and the response handshake.
      state_d     = S_IDLE;
      rsp_valid_d = 1'b0;
      c_valid_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_d    = req_op;
            word_d  = word_s;
            opa_d   = req_opa;
            opb_d   = req_opb;
            neg_d   = neg_s;
            mag_a_d = {{XLEN{1'b0}}, mag_a_s};
            mag_b_d = mag_b_s;
            acc_d   = {PW{1'b0}};
            cnt_d   = word_s ? CW'(N_WORD - 1) : CW'(N_FULL - 1);
            if (hit_s) begin
              state_d      = S_DONE;
              rsp_valid_d  = 1'b1;
              rsp_result_d = hit_result_s;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          acc_d   = acc_q + pp_s;
          mag_a_d = mag_a_q << BPC;
          mag_b_d = mag_b_q >> BPC;
          if (cnt_q == {CW{1'b0}}) begin
            state_d = S_SIGN;
          end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_SIGN: begin
          acc_d        = signed_prod_s;
          rsp_result_d = sign_result_s;
          rsp_valid_d  = 1'b1;
          state_d      = S_DONE;
          // Word results are not full products, so they never enter the cache.
          if (!word_q) begin
            c_valid_d = 1'b1;
            c_opa_d   = opa_q;
            c_opb_d   = opb_q;
            c_op_d    = op_q;
            c_prod_d  = signed_prod_s;
          end else begin
            c_valid_d = c_valid_q;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      acc_q        <= {PW{1'b0}};
      mag_a_q      <= {PW{1'b0}};
      mag_b_q      <= {XLEN{1'b0}};
      neg_q        <= 1'b0;
      op_q         <= 2'd0;
      word_q       <= 1'b0;
      opa_q        <= {XLEN{1'b0}};
      opb_q        <= {XLEN{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {XLEN{1'b0}};
      busy_q       <= 1'b0;
      c_valid_q    <= 1'b0;
      c_opa_q      <= {XLEN{1'b0}};
      c_opb_q      <= {XLEN{1'b0}};
      c_op_q       <= 2'd0;
      c_prod_q     <= {PW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mag_a_q      <= mag_a_d;
      mag_b_q      <= mag_b_d;
      neg_q        <= neg_d;
      op_q         <= op_d;
      word_q       <= word_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
      c_valid_q    <= c_valid_d;
      c_opa_q      <= c_opa_d;
      c_opb_q      <= c_opb_d;
      c_op_q       <= c_op_d;
      c_prod_q     <= c_prod_d;
    end
  end

endmodule

// File: tb/tb_riscv_mul_iter.sv
// Testbench for riscv_mul_iter: one XLEN=32/BPC=4 instance and one
// XLEN=64/BPC=8 instance sharing clock, reset, flush and request payload.
module tb_riscv_mul_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        rsp_ready;
  logic [1:0]  req_op;
  logic        req_word;
  logic [63:0] req_opa;
  logic [63:0] req_opb;

  logic        req_valid32, req_ready32, rsp_valid32, busy32;
  logic [31:0] rsp_result32;
  logic        req_valid64, req_ready64, rsp_valid64, busy64;
  logic [63:0] rsp_result64;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference cache state per instance (0: 32-bit, 1: 64-bit)
  logic        cv  [2];
  logic [63:0] ca  [2];
  logic [63:0] cb  [2];
  logic [1:0]  cop [2];

  riscv_mul_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .ENABLE_CACHE(1)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_op(req_op),
    .req_word(req_word), .req_opa(req_opa[31:0]), .req_opb(req_opb[31:0]),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready), .rsp_result(rsp_result32),
    .busy(busy32)
  );

  riscv_mul_iter #(.XLEN(64), .BITS_PER_CYCLE(8), .ENABLE_CACHE(1)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_op(req_op),
    .req_word(req_word), .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready), .rsp_result(rsp_result64),
    .busy(busy64)
  );

  function automatic logic get_rv(input int sel);
    return (sel == 0) ? rsp_valid32 : rsp_valid64;
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? req_ready32 : req_ready64;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy32 : busy64;
  endfunction
  function automatic logic [63:0] get_res(input int sel);
    return (sel == 0) ? {32'd0, rsp_result32} : rsp_result64;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) req_valid32 = v;
    else          req_valid64 = v;
  endtask

  // Architectural result: extend operands per op signedness, multiply at 128 bits.
  function automatic logic [63:0] ref_result(input int sel, input logic [1:0] op,
                                             input logic weff, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] ea, eb, p;
    if (sel == 0) begin
      ea = (op == 2'd3) ? {96'd0, a[31:0]} : {{96{a[31]}}, a[31:0]};
      eb = (op >= 2'd2) ? {96'd0, b[31:0]} : {{96{b[31]}}, b[31:0]};
      p  = ea * eb;
      return (op == 2'd0) ? {32'd0, p[31:0]} : {32'd0, p[63:32]};
    end else if (weff) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
      p  = ea * eb;
      return {{32{p[31]}}, p[31:0]};
    end else begin
      ea = (op == 2'd3) ? {64'd0, a} : {{64{a[63]}}, a};
      eb = (op >= 2'd2) ? {64'd0, b} : {{64{b[63]}}, b};
      p  = ea * eb;
      return (op == 2'd0) ? p[63:0] : p[127:64];
    end
  endfunction

  // Expected result and latency (cycles after the accept cycle), updating the cache model.
  task automatic predict(input int sel, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] exp, output int lat);
    logic weff;
    logic hit;
    int   n;
    weff = (sel == 1) && word;
    n    = weff ? 4 : 8;
    hit  = cv[sel] && !weff && (a == ca[sel]) && (b == cb[sel]) &&
           ((op == 2'd0) || (op == cop[sel]));
    lat  = hit ? 1 : n + 2;
    if (!hit && !weff) begin
      cv[sel]  = 1'b1;
      ca[sel]  = a;
      cb[sel]  = b;
      cop[sel] = op;
    end
    exp = ref_result(sel, op, weff, a, b);
  endtask

  task automatic model_invalidate();
    cv[0] = 1'b0;
    cv[1] = 1'b0;
  endtask

  // Full transaction: accept, latency, result, optional stall, release.
  task automatic run_op(input int sel, input logic [1:0] op, input logic word,
                        input logic [63:0] a_in, input logic [63:0] b_in,
                        input int stall, input string tag);
    logic [63:0] a, b, exp, held;
    int lat_exp, lat;
    a = (sel == 0) ? {32'd0, a_in[31:0]} : a_in;
    b = (sel == 0) ? {32'd0, b_in[31:0]} : b_in;
    predict(sel, op, word, a, b, exp, lat_exp);
    @(negedge clk);
    req_op = op; req_word = word; req_opa = a; req_opb = b;
    rsp_ready = (stall == 0);
    set_valid(sel, 1'b1);
    tests_run++;
    if (get_rdy(sel) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready: req_ready=%b expected 1", tag, get_rdy(sel));
    end
    @(posedge clk);
    #1 set_valid(sel, 1'b0);
    @(negedge clk);
    lat = 1;
    while (get_rv(sel) !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != lat_exp) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", tag, lat, lat_exp);
    end
    tests_run++;
    if (get_res(sel) !== exp) begin
      tests_failed++;
      $display("FAIL %s_result: got %h expected %h", tag, get_res(sel), exp);
    end
    held = get_res(sel);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      tests_run++;
      if (get_rv(sel) !== 1'b1 || get_res(sel) !== held || get_rdy(sel) !== 1'b0 ||
          get_busy(sel) !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_stall: valid=%b result=%h ready=%b busy=%b expected 1/%h/0/1",
                 tag, get_rv(sel), get_res(sel), get_rdy(sel), get_busy(sel), held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (get_rv(sel) !== 1'b0 || get_rdy(sel) !== 1'b1 || get_busy(sel) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_release: valid=%b ready=%b busy=%b expected 0/1/0",
               tag, get_rv(sel), get_rdy(sel), get_busy(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_op = 2'd0; req_word = 1'b0; req_opa = 64'd0; req_opb = 64'd0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready32 !== 1'b0 || rsp_valid32 !== 1'b0 || busy32 !== 1'b0 ||
        rsp_result32 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset32: ready=%b valid=%b busy=%b result=%h expected 0/0/0/0",
               req_ready32, rsp_valid32, busy32, rsp_result32);
    end
    tests_run++;
    if (req_ready64 !== 1'b0 || rsp_valid64 !== 1'b0 || busy64 !== 1'b0 ||
        rsp_result64 !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset64: ready=%b valid=%b busy=%b result=%h expected 0/0/0/0",
               req_ready64, rsp_valid64, busy64, rsp_result64);
    end
    rst = 1'b0;
    model_invalidate();
    #1;
    tests_run++;
    if (req_ready32 !== 1'b1 || req_ready64 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", req_ready32, req_ready64);
    end
  endtask

  task automatic test_directed();
    run_op(0, 2'd0, 1'b0, 64'hFFFFFFFD, 64'd7, 0, "mul_neg");
    run_op(0, 2'd1, 1'b0, 64'h80000000, 64'h80000000, 0, "mulh_min");
    run_op(0, 2'd2, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mulhsu_ones");
    run_op(0, 2'd3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mulhu_ones");
  endtask

  task automatic test_cache();
    run_op(0, 2'd3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "cache_fill");
    run_op(0, 2'd0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "cache_hit_mul");
    run_op(0, 2'd1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "cache_miss_mulh");
    run_op(0, 2'd0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "cache_hit_after_mulh");
  endtask

  task automatic test_backpressure();
    run_op(0, 2'd1, 1'b0, 64'h12345678, 64'h9ABCDEF0, 5, "stall32");
    run_op(1, 2'd3, 1'b0, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 5, "stall64");
  endtask

  // Abort a miss in its 3rd CALC cycle via flush (use_rst=0) or reset (use_rst=1).
  task automatic test_abort(input logic use_rst, input string tag);
    logic [63:0] x, y;
    int seen;
    x = {32'd0, $urandom()};
    y = {32'd0, $urandom()};
    run_op(0, 2'd1, 1'b0, x, y, 0, {tag, "_prefill"});
    @(negedge clk);
    req_op = 2'd3; req_opa = x; req_opb = y; req_word = 1'b0; rsp_ready = 1'b1;
    req_valid32 = 1'b1;
    @(posedge clk);
    #1 req_valid32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    #1;
    if (use_rst) begin
      tests_run++;
      if (req_ready32 !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_ready_in_reset: got %b expected 0", tag, req_ready32);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0;
    model_invalidate();
    @(negedge clk);
    tests_run++;
    if (req_ready32 !== 1'b1 || rsp_valid32 !== 1'b0 || busy32 !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: ready=%b valid=%b busy=%b expected 1/0/0",
               tag, req_ready32, rsp_valid32, busy32);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid32 === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL %s_no_rsp: rsp_valid high %0d cycles expected 0", tag, seen);
    end
    run_op(0, 2'd0, 1'b0, x, y, 0, {tag, "_miss_after"});
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, b1, a2, b2, e1, e2, r1;
    int l1, l2, k, lat;
    logic got1;
    a1 = {32'd0, $urandom()}; b1 = {32'd0, $urandom()};
    a2 = {32'd0, $urandom()}; b2 = {32'd0, $urandom()};
    predict(0, 2'd1, 1'b0, a1, b1, e1, l1);
    predict(0, 2'd3, 1'b0, a2, b2, e2, l2);
    @(negedge clk);
    req_op = 2'd1; req_word = 1'b0; req_opa = a1; req_opb = b1; rsp_ready = 1'b1;
    req_valid32 = 1'b1;
    @(posedge clk);
    #1 req_op = 2'd3; req_opa = a2; req_opb = b2;
    k = 0; got1 = 1'b0; r1 = 64'd0;
    do begin
      @(negedge clk);
      k++;
      if (rsp_valid32 === 1'b1 && !got1) begin
        got1 = 1'b1;
        r1 = {32'd0, rsp_result32};
      end
    end while (req_ready32 !== 1'b1 && k < 100);
    tests_run++;
    if (k != l1 + 1) begin
      tests_failed++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart expected %0d", k, l1 + 1);
    end
    tests_run++;
    if (r1 !== e1) begin
      tests_failed++;
      $display("FAIL b2b_first_result: got %h expected %h", r1, e1);
    end
    @(posedge clk);
    #1 req_valid32 = 1'b0;
    @(negedge clk);
    lat = 1;
    while (rsp_valid32 !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != l2 || {32'd0, rsp_result32} !== e2) begin
      tests_failed++;
      $display("FAIL b2b_second: latency %0d result %h expected %0d %h", lat, rsp_result32, l2, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_word64();
    run_op(1, 2'd0, 1'b1, 64'h000000007FFFFFFF, 64'd2, 0, "mulw_ovf");
    run_op(1, 2'd0, 1'b1, 64'hDEADBEEF80000000, 64'h12345678FFFFFFFF, 0, "mulw_hi_ignored");
    run_op(1, 2'd1, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 0, "mulh64_min");
    run_op(1, 2'd0, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 0, "mul64_hit");
    run_op(0, 2'd0, 1'b1, 64'hFFFFFFFD, 64'd7, 0, "word_ignored32");
  endtask

  task automatic test_random();
    logic [63:0] specials [5];
    logic [63:0] pa [2];
    logic [63:0] pb [2];
    logic        have [2];
    logic [63:0] a, b;
    logic [1:0]  op;
    logic        word;
    int          sel;
    specials[0] = 64'd0;
    specials[1] = 64'hFFFFFFFFFFFFFFFF;
    specials[2] = 64'h8000000000000000;
    specials[3] = 64'h0000000080000000;
    specials[4] = 64'd1;
    have[0] = 1'b0; have[1] = 1'b0;
    pa[0] = 64'd0; pa[1] = 64'd0; pb[0] = 64'd0; pb[1] = 64'd0;
    for (int t = 0; t < 40; t++) begin
      sel  = int'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 3));
      word = (sel == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      if (sel == 1 && word) op = 2'd0;
      if (have[sel] && $urandom_range(0, 2) == 0) begin
        a = pa[sel];
        b = pb[sel];
      end else begin
        a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : {$urandom(), $urandom()};
        b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : {$urandom(), $urandom()};
      end
      if (sel == 0) begin
        a = {32'd0, a[31:0]};
        b = {32'd0, b[31:0]};
      end
      pa[sel] = a; pb[sel] = b; have[sel] = 1'b1;
      run_op(sel, op, word, a, b, int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cache();
    test_backpressure();
    test_abort(1'b0, "flush");
    test_abort(1'b1, "rst");
    test_back_to_back();
    test_word64();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
